truth_table_sweeper: RTL



---
 rtl/truth_table_sweeper.sv | 121 ++++++++++++
 1 files changed

// File: rtl/truth_table_sweeper.sv
// Clocked sweep of a 4-input function block.
// Builds its truth table, counts the ones and compares the table against an expected one.
module truth_table_sweeper #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2**N_IN-1:0]   expected,
  output logic [N_IN-1:0]      vec,
  input  logic                 fn_in,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   table_out,
  output logic [N_IN:0]        ones_count,
  output logic                 match,
  output logic [N_IN-1:0]      mismatch_idx
);

  localparam int TW = 2**N_IN;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [CW-1:0]   settle_q, settle_d;
  logic [TW-1:0]   table_q, table_d;
  logic [N_IN:0]   ones_q, ones_d;
  logic            match_q, match_d;
  logic [N_IN-1:0] midx_q, midx_d;
  logic [TW-1:0]   exp_q, exp_d;
  logic            capture;

  assign capture = (settle_q == CW'(SETTLE - 1));

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    settle_d = settle_q;
    table_d  = table_q;
    ones_d   = ones_q;
    match_d  = match_q;
    midx_d   = midx_q;
    exp_d    = exp_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          exp_d    = expected;
          vec_d    = '0;
          settle_d = '0;
          table_d  = '0;
          ones_d   = '0;
          match_d  = 1'b1;
          midx_d   = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        settle_d = settle_q + CW'(1);
        if (capture) begin
          table_d[vec_q] = fn_in;
          ones_d         = ones_q + {{N_IN{1'b0}}, fn_in};
          // Only the first differing index is kept.
          if ((fn_in != exp_q[vec_q]) && match_q) begin
            match_d = 1'b0;
            midx_d  = vec_q;
          end
          settle_d = '0;
          if (&vec_q) begin
            state_d = DONE;
          end else begin
            vec_d = vec_q + {{(N_IN-1){1'b0}}, 1'b1};
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      vec_q    <= '0;
      settle_q <= '0;
      table_q  <= '0;
      ones_q   <= '0;
      match_q  <= 1'b0;
      midx_q   <= '0;
      exp_q    <= '0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      settle_q <= settle_d;
      table_q  <= table_d;
      ones_q   <= ones_d;
      match_q  <= match_d;
      midx_q   <= midx_d;
      exp_q    <= exp_d;
    end
  end

  assign vec          = vec_q;
  assign busy         = (state_q == RUN);
  assign done         = (state_q == DONE);
  assign table_out    = table_q;
  assign ones_count   = ones_q;
  assign match        = match_q;
  assign mismatch_idx = midx_q;

endmodule
